stack_unit: RTL and testbench
=============================

# stack_unit

Parametrised hardware stack that replaces the fixed single-register stack pointer of the single-cycle core. It provides PUSH, POP, CALL, RET, PEEK and CLEAR with a valid/ready command handshake and a held response. It also has overflow and underflow detection and an architecturally visible memory-style stack pointer. The block sits beside the PC control logic: the core issues stack commands, and RET/POP data returns to the PC mux or the register write-back mux.

## Interface
- DATA_W, 32: stack entry width (return addresses and pushed register values).
- DEPTH, 16: number of entries; must be a power of two, at least 2.
- BASE_ADDR, 32'h0000_03FC: value of `sp_addr` when the stack is empty.
- WORD_BYTES, 4: byte stride of `sp_addr` per entry.
- CNT_W, $clog2(DEPTH)+1: occupancy counter width (derived).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- cmd_valid  in  1  a command is presented.
- cmd_ready  out  1  the block accepts a command this cycle.
- cmd_op  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 PEEK, 6 CLEAR; 7 is treated as NOP.
- push_data  in  DATA_W  value written by PUSH.
- call_pc  in  DATA_W  PC of the CALL instruction; the block stores call_pc + WORD_BYTES.
- rsp_valid  out  1  response data is valid.
- rsp_ready  in  1  the consumer takes the response.
- rsp_data  out  DATA_W  popped or peeked value.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- sp_addr  out  32  BASE_ADDR − WORD_BYTES·count; the stack grows down.
- full, empty  out  1  count==DEPTH, count==0.
- err_overflow, err_underflow  out  1  sticky error flags.

## Operation
- A command is accepted when cmd_valid && cmd_ready.
- cmd_ready = (state==IDLE).
- State machine has two states, IDLE and RESP:
  - IDLE → RESP on an accepted POP, RET or PEEK when not empty.
  - RESP → IDLE when rsp_ready is high.
  - All other accepted commands stay in IDLE.
- PUSH/CALL when not full: mem[count] ← data, where data is push_data for PUSH and call_pc+WORD_BYTES for CALL; count+1.
- PUSH/CALL when full: storage and count are unchanged; err_overflow ← 1; no response.
- POP/RET when not empty: rsp_data ← mem[count−1]; count−1.
- PEEK when not empty: same as POP but count is unchanged.
- POP/RET/PEEK when empty: err_underflow ← 1; rsp_data ← 0; state stays IDLE; no response.
- CLEAR: count ← 0; both error flags ← 0; storage contents are don't-care.
- NOP: no effect.
- Arithmetic: call_pc+WORD_BYTES is truncated to DATA_W (wraps). sp_addr is computed modulo 2^32.
- Error flags are cleared only by CLEAR or reset.

## Timing
- Reset (rst==0 at a rising edge) sets:
  - state IDLE, count 0, rsp_valid 0, rsp_data 0
  - err_overflow 0, err_underflow 0
  - full 0, empty 1, sp_addr BASE_ADDR, cmd_ready 1 from the following cycle.
- Reset overrides any in-flight command or pending response. An unconsumed response is discarded.
- Latency:
  - count, full, empty and sp_addr reflect an accepted command in the cycle after acceptance. They are registered outputs, not combinational from cmd_*.
  - POP/RET/PEEK: rsp_valid rises the cycle after acceptance.
  - rsp_data is stable while rsp_valid is high.
- rsp_valid falls the cycle after a cycle with rsp_valid && rsp_ready.
- Back-to-back throughput:
  - PUSH/CALL/CLEAR/NOP: one per cycle.
  - POP/RET/PEEK: one per two cycles at best (with rsp_ready tied high).
- Commands presented while cmd_ready==0 are ignored and not queued. The issuer must hold cmd_valid.
- Boundaries:
  - PUSH at count==DEPTH−1 → count==DEPTH, full=1.
  - POP at count==1 → count 0, empty=1.
  - Count never exceeds DEPTH and never underflows.

## Test plan
- Reset with DEPTH=16 → count=0, empty=1, full=0, sp_addr=0x3FC, rsp_valid=0, both error flags 0, cmd_ready=1.
- PUSH 0xA, 0xB, 0xC on consecutive cycles, then POP ×3 with rsp_ready=1 → rsp_data 0xC, 0xB, 0xA; count 3→0; sp_addr 0x3F0→0x3FC.
- CALL with call_pc=0x100, then PEEK, then RET; hold rsp_ready=0 for 3 cycles on RET:
  - PEEK gives 0x104 with count unchanged.
  - RET rsp_data=0x104 held stable and cmd_ready=0 until rsp_ready is asserted.
- Fill 16 entries, then PUSH 0xFF → full=1, err_overflow=1, count=16, top still the 16th value. Then CLEAR → count=0, both error flags 0.
- POP on empty → err_underflow=1, no rsp_valid pulse, cmd_ready stays 1. A following PUSH 0x5 succeeds with count=1.
- CALL with call_pc=0xFFFF_FFFC → stored 0x0000_0000. Assert rst=0 mid-RESP → rsp_valid=0 and count=0 on the next cycle.

Source files
------------

// File: rtl/stack_unit.sv
// Parametrised LIFO stack for call/return addresses and pushed register values,
// with a valid/ready command port, a held response and sticky overflow/underflow flags.
module stack_unit #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_03FC,
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] push_data,
  input  logic [DATA_W-1:0] call_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [CNT_W-1:0]  count,
  output logic [31:0]       sp_addr,
  output logic              full,
  output logic              empty,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_CALL  = 3'd3;
  localparam logic [2:0] OP_RET   = 3'd4;
  localparam logic [2:0] OP_PEEK  = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    count_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_valid_q;
  logic                ovf_q;
  logic                udf_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                accept;
  logic                is_push;
  logic                is_pop;
  logic                is_peek;
  logic                full_w;
  logic                empty_w;
  logic [AW-1:0]       wr_idx;
  logic [AW-1:0]       top_idx;
  logic [DATA_W-1:0]   wdata_d;

  assign accept  = cmd_valid && (state_q == IDLE);
  assign is_push = (cmd_op == OP_PUSH) || (cmd_op == OP_CALL);
  assign is_pop  = (cmd_op == OP_POP)  || (cmd_op == OP_RET);
  assign is_peek = (cmd_op == OP_PEEK);
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);

  // Index wraps at DEPTH; top_idx is only used when not empty, wr_idx only when not full.
  assign wr_idx  = count_q[AW-1:0];
  assign top_idx = count_q[AW-1:0] - AW'(1);
  assign wdata_d = (cmd_op == OP_CALL) ? (call_pc + DATA_W'(WORD_BYTES)) : push_data;

  always_ff @(posedge clk) begin
    if (accept && is_push && !full_w) begin
      mem_q[wr_idx] <= wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (is_push) begin
              if (full_w) ovf_q <= 1'b1;
              else        count_q <= count_q + CNT_W'(1);
            end else if (is_pop || is_peek) begin
              if (empty_w) begin
                udf_q      <= 1'b1;
                rsp_data_q <= '0;
              end else begin
                rsp_data_q  <= mem_q[top_idx];
                rsp_valid_q <= 1'b1;
                state_q     <= RESP;
                if (is_pop) count_q <= count_q - CNT_W'(1);
              end
            end else if (cmd_op == OP_CLEAR) begin
              count_q <= '0;
              ovf_q   <= 1'b0;
              udf_q   <= 1'b0;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign count         = count_q;
  assign full          = full_w;
  assign empty         = empty_w;
  assign err_overflow  = ovf_q;
  assign err_underflow = udf_q;
  assign sp_addr       = BASE_ADDR - (32'(WORD_BYTES) * 32'(count_q));

endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_stack_unit;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = 3'd0;
  logic [DATA_W-1:0] push_data = '0;
  logic [DATA_W-1:0] call_pc = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic [CNT_W-1:0]  count;
  logic [31:0]       sp_addr;
  logic              full, empty, err_overflow, err_underflow;

  stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(32'h0000_03FC), .WORD_BYTES(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .push_data(push_data), .call_pc(call_pc), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .count(count), .sp_addr(sp_addr), .full(full), .empty(empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a queue whose back is the top of stack.
  logic [31:0] stk[$];
  bit          m_pend = 0;
  logic [31:0] m_rsp  = '0;
  bit          m_ovf  = 0;
  bit          m_udf  = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (!rst) begin
      stk.delete();
      m_pend = 0; m_rsp = '0; m_ovf = 0; m_udf = 0;
      chk_en = 1;
    end else if (m_pend) begin
      if (rsp_ready) m_pend = 0;
    end else if (cmd_valid) begin
      case (cmd_op)
        3'd1, 3'd3: begin
          if (stk.size() < DEPTH) stk.push_back(cmd_op == 3'd1 ? push_data : call_pc + 32'd4);
          else m_ovf = 1;
        end
        3'd2, 3'd4, 3'd5: begin
          if (stk.size() == 0) begin
            m_udf = 1; m_rsp = '0;
          end else begin
            m_rsp  = stk[stk.size()-1];
            m_pend = 1;
            if (cmd_op != 3'd5) void'(stk.pop_back());
          end
        end
        3'd6: begin
          stk.delete(); m_ovf = 0; m_udf = 0;
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("count", 32'(count), 32'(stk.size()));
      check("sp_addr", sp_addr, 32'h3FC - 32'(4 * stk.size()));
      check("full", 32'(full), 32'(stk.size() == DEPTH));
      check("empty", 32'(empty), 32'(stk.size() == 0));
      check("rsp_valid", 32'(rsp_valid), 32'(m_pend));
      check("cmd_ready", 32'(cmd_ready), 32'(!m_pend));
      check("err_overflow", 32'(err_overflow), 32'(m_ovf));
      check("err_underflow", 32'(err_underflow), 32'(m_udf));
      if (m_pend) check("rsp_data", rsp_data, m_rsp);
    end
  end

  // Drive one cycle of inputs, then return just after the edge that samples them.
  task automatic step(input bit r, input bit v, input logic [2:0] op,
                      input logic [31:0] d, input bit rr);
    @(negedge clk);
    rst = r; cmd_valid = v; cmd_op = op; push_data = d; call_pc = d; rsp_ready = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    step(0, 0, 0, 0, 0);
    step(0, 1, 3'd1, 32'h77, 0);
    step(1, 0, 0, 0, 0);
    check("lit_reset_count", 32'(count), 32'd0);
    check("lit_reset_empty", 32'(empty), 32'd1);
    check("lit_reset_full", 32'(full), 32'd0);
    check("lit_reset_sp", sp_addr, 32'h3FC);
    check("lit_reset_ready", 32'(cmd_ready), 32'd1);
    check("lit_reset_errs", 32'({err_overflow, err_underflow}), 32'd0);

    step(1, 1, 3'd1, 32'hA, 1);
    step(1, 1, 3'd1, 32'hB, 1);
    step(1, 1, 3'd1, 32'hC, 1);
    check("lit_push3_count", 32'(count), 32'd3);
    check("lit_push3_sp", sp_addr, 32'h3F0);
    step(1, 1, 3'd2, 0, 1);
    check("lit_pop1_data", rsp_data, 32'hC);
    check("lit_pop1_valid", 32'(rsp_valid), 32'd1);
    step(1, 0, 3'd0, 0, 1);
    step(1, 1, 3'd2, 0, 1);
    check("lit_pop2_data", rsp_data, 32'hB);
    step(1, 0, 3'd0, 0, 1);
    step(1, 1, 3'd2, 0, 1);
    check("lit_pop3_data", rsp_data, 32'hA);
    step(1, 0, 3'd0, 0, 1);
    check("lit_pop3_sp", sp_addr, 32'h3FC);

    step(1, 1, 3'd3, 32'h100, 1);
    step(1, 1, 3'd5, 0, 1);
    check("lit_peek_data", rsp_data, 32'h104);
    check("lit_peek_count", 32'(count), 32'd1);
    step(1, 0, 3'd0, 0, 1);
    step(1, 1, 3'd4, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 3'd1, 32'hDEAD, 0);
      check("lit_ret_hold_data", rsp_data, 32'h104);
      check("lit_ret_hold_ready", 32'(cmd_ready), 32'd0);
    end
    step(1, 0, 3'd0, 0, 1);
    check("lit_ret_done_valid", 32'(rsp_valid), 32'd0);
    check("lit_ret_count", 32'(count), 32'd0);

    for (int i = 0; i < DEPTH; i++) step(1, 1, 3'd1, 32'h200 + 32'(i), 1);
    step(1, 1, 3'd1, 32'hFF, 1);
    check("lit_full", 32'(full), 32'd1);
    check("lit_ovf", 32'(err_overflow), 32'd1);
    check("lit_full_count", 32'(count), 32'd16);
    step(1, 1, 3'd5, 0, 1);
    check("lit_full_top", rsp_data, 32'h20F);
    step(1, 0, 3'd0, 0, 1);
    step(1, 1, 3'd6, 0, 1);
    check("lit_clear_count", 32'(count), 32'd0);
    check("lit_clear_errs", 32'({err_overflow, err_underflow}), 32'd0);

    step(1, 1, 3'd2, 0, 1);
    check("lit_udf", 32'(err_underflow), 32'd1);
    check("lit_udf_valid", 32'(rsp_valid), 32'd0);
    check("lit_udf_ready", 32'(cmd_ready), 32'd1);
    step(1, 1, 3'd1, 32'h5, 1);
    check("lit_after_udf_count", 32'(count), 32'd1);
    check("lit_udf_sticky", 32'(err_underflow), 32'd1);

    step(1, 1, 3'd3, 32'hFFFF_FFFC, 0);
    step(1, 1, 3'd5, 0, 0);
    check("lit_wrap_data", rsp_data, 32'h0);
    step(1, 0, 3'd0, 0, 0);
    step(0, 0, 3'd0, 0, 0);
    check("lit_rst_resp_valid", 32'(rsp_valid), 32'd0);
    check("lit_rst_resp_count", 32'(count), 32'd0);
    step(1, 1, 3'd7, 0, 1);
    check("lit_op7_count", 32'(count), 32'd0);
    step(1, 0, 3'd0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
